pipeline_flow_ctrl: RTL
=======================

# pipeline_flow_ctrl

Pipeline flow controller for the six-stage core (IF, ID, RR, EX, MEM, WB). It drives the load/hold enables and bubble flushes of the five inter-stage pipeline registers and the PC, which are otherwise free-running. It resolves load-use stalls and branch/R7 redirects, and sequences multi-cycle LM/SM instructions in RR into one micro-op per transferred register.

## Interface
Parameters:
- NREGS, 8, architectural register count; width of the LM/SM register list.
- IDXW, 3, register index width, log2(NREGS).

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- rr_valid  in  1  RR stage holds a real instruction.
- rr_uses_a, rr_uses_b  in  1 each  RR instruction reads source A / source B.
- rr_src_a, rr_src_b  in  IDXW each  RR source register indices.
- rr_is_lmsm  in  1  RR instruction is LM or SM.
- rr_reglist  in  NREGS  LM/SM register list; bit i selects Ri.
- ex_valid, ex_is_load  in  1 each  EX holds a valid load.
- ex_rd  in  IDXW  EX destination register.
- ex_branch_taken  in  1  EX resolved a taken branch or jump.
- wb_r7_write  in  1  WB writes R7 (the PC).
- pc_write_n  out  1  0 = PC loads, 1 = PC holds.
- pipe1_write_n … pipe5_write_n  out  1 each  0 = register loads, 1 = register holds.
- pipe1_flush … pipe5_flush  out  1 each  1 = register captures a bubble (valid cleared) this edge.
- lmsm_active  out  1  sequencer is issuing LM/SM micro-ops.
- lmsm_reg  out  IDXW  register index of the current micro-op.
- lmsm_offset  out  IDXW+1  word offset of the current micro-op from the base address (0..NREGS-1).

## Operation
- FSM states: IDLE and SEQ. It holds a NREGS-bit remaining mask and an offset counter.
- All write_n and flush outputs are combinational from the inputs and state. State is registered.
- Events are evaluated with a fixed priority; the highest active event wins, and lower events are ignored that cycle:
  1. **R7 redirect** (wb_r7_write): pipe1..pipe4 flush; PC loads; FSM goes to IDLE with mask cleared.
  2. **Branch redirect** (ex_branch_taken): pipe1..pipe3 flush; PC loads; FSM goes to IDLE.
  3. **Load-use stall**: condition is ex_valid & ex_is_load & rr_valid & ((rr_uses_a & rr_src_a==ex_rd) | (rr_uses_b & rr_src_b==ex_rd)).
     - PC, pipe1 and pipe2 hold; pipe3 flushes.
     - FSM state and mask are unchanged.
  4. **LM/SM sequencing**:
     - Start: in IDLE with rr_valid & rr_is_lmsm, the mask is loaded with rr_reglist.
     - Each issue cycle emits the lowest set bit as lmsm_reg and the current offset, then clears that bit and increments the offset.
     - On every issue cycle except the last, PC, pipe1 and pipe2 hold.
     - On the last issue cycle (popcount of the remaining mask is 1), everything loads and the FSM returns to IDLE.
     - A single-bit list issues in one cycle with no hold and never enters SEQ.
     - An empty list (rr_reglist==0) flushes pipe3 (instruction retired as a NOP), with no hold and no state change.
  5. **Default**: all write_n are 0 and all flushes are 0.
- pipe4 and pipe5 always load; only an R7 redirect flushes pipe4.
- lmsm_active = (state==SEQ) | (IDLE cycle starting a multi-bit list). Outside sequencing, lmsm_reg and lmsm_offset are 0.

## Timing
- Reset values:
  - all write_n 0 and all flush 0;
  - lmsm_active 0, lmsm_reg 0, lmsm_offset 0;
  - FSM in IDLE with mask cleared.
- A reset asserted mid-sequence aborts the sequence at the next edge.
- Stall and flush outputs take effect at the same edge the condition is seen (zero-cycle decision latency).
- Load-use stall lasts exactly one cycle, because the load advances to MEM.
- An LM/SM with k set bits occupies RR for k cycles and holds upstream stages for k-1 cycles.
  - A load-use stall arriving during SEQ freezes the mask and offset for that cycle; the sequence resumes afterwards.
- Redirect in the same cycle as the last LM/SM issue: the redirect wins and the micro-op is flushed.

## Structure
- Shared package (pipeline-wide):
  - NREGS and IDXW;
  - R7 index constant;
  - FSM state encoding (IDLE, SEQ);
  - stage-number constants used in flush/hold naming.
- Sub-module: lmsm_bitscan, a combinational lowest-set-bit priority encoder over NREGS bits. It outputs the index, an "any" flag and a "last" flag (exactly one bit set), and is also reusable by decode.

## Test plan
- **Load-use:** ex_is_load, ex_rd=3, rr_uses_a, rr_src_a=3 → one cycle with pc_write_n=pipe1_write_n=pipe2_write_n=1 and pipe3_flush=1; next cycle all loads.
- **LM sequence:** rr_reglist=8'b1010_0100 → three issue cycles with lmsm_reg=2,5,7 and lmsm_offset=0,1,2; upstream hold for 2 cycles; FSM returns to IDLE.
- **Edge lists:** rr_reglist=0 → pipe3_flush=1 for one cycle, no hold. rr_reglist=8'h01 → single issue with lmsm_reg=0 and no hold.
- **Redirect abort:** ex_branch_taken asserted in the 2nd cycle of an 8'hFF sequence → pipe1..pipe3 flush, lmsm_active=0 next cycle, FSM in IDLE.
- **Priority:** wb_r7_write together with ex_branch_taken and a load-use condition → pipe1..pipe4 flush, pc_write_n=0, no hold.
- **Reset mid-sequence:** reset asserted during SEQ → at the next edge all outputs are at reset values; with reset deasserted and no event, the default (all load) holds.

Source files
------------

// File: rtl/pipeline_flow_ctrl_pkg.sv
// Shared pipeline-wide constants and types for the six-stage core
// (IF, ID, RR, EX, MEM, WB).
//   NREGS / IDXW : architectural register count and index width
//   R7Idx        : index of the PC-mapped register
//   flow_state_e : flow controller FSM encoding
//   Stage*/Pipe* : stage numbers and inter-stage register numbers
package pipeline_flow_ctrl_pkg;

  localparam int unsigned NREGS = 8;
  localparam int unsigned IDXW  = 3;

  localparam logic [IDXW-1:0] R7Idx = IDXW'(7);

  typedef enum logic {
    StIdle = 1'b0,
    StSeq  = 1'b1
  } flow_state_e;

  // Stage numbers.
  localparam int unsigned StageIf  = 0;
  localparam int unsigned StageId  = 1;
  localparam int unsigned StageRr  = 2;
  localparam int unsigned StageEx  = 3;
  localparam int unsigned StageMem = 4;
  localparam int unsigned StageWb  = 5;

  // Inter-stage register N sits between stage N-1 and stage N.
  localparam int unsigned PipeIfId  = StageId;
  localparam int unsigned PipeIdRr  = StageRr;
  localparam int unsigned PipeRrEx  = StageEx;
  localparam int unsigned PipeExMem = StageMem;
  localparam int unsigned PipeMemWb = StageWb;
  localparam int unsigned NumPipes  = 5;

endpackage

// File: rtl/lmsm_bitscan.sv
// Combinational lowest-set-bit priority encoder.
//   vec  : input bit vector (Width bits)
//   idx  : index of the lowest set bit (0 when vec is empty)
//   any  : at least one bit set
//   last : exactly one bit set
module lmsm_bitscan #(
  parameter int unsigned Width = 8,
  parameter int unsigned IdxW  = 3
) (
  input  logic [Width-1:0] vec,
  output logic [IdxW-1:0]  idx,
  output logic             any,
  output logic             last
);

  always_comb begin
    idx = '0;
    // Scan downward so the lowest set bit is written last and wins.
    for (int i = int'(Width) - 1; i >= 0; i--) begin
      if (vec[i]) idx = IdxW'(i);
    end
    any  = |vec;
    // Clearing the lowest set bit leaves zero only for a one-hot vector.
    last = any & ~(|(vec & (vec - Width'(1))));
  end

endmodule

// File: rtl/pipeline_flow_ctrl.sv
// Pipeline flow controller: drives the PC and five inter-stage register
// load/hold enables and bubble flushes, resolves load-use stalls and
// branch/R7 redirects, and sequences LM/SM in RR into per-register micro-ops.
//   clk, reset                  : clock, synchronous active-high reset
//   rr_*                        : RR instruction info (sources, LM/SM list)
//   ex_valid/ex_is_load/ex_rd   : EX load destination for hazard check
//   ex_branch_taken             : EX redirect
//   wb_r7_write                 : WB writes R7 (redirect)
//   pc_write_n, pipeN_write_n   : 0 = load, 1 = hold
//   pipeN_flush                 : 1 = capture a bubble this edge
//   lmsm_active/reg/offset      : current LM/SM micro-op
module pipeline_flow_ctrl #(
  parameter int unsigned NREGS = pipeline_flow_ctrl_pkg::NREGS,
  parameter int unsigned IDXW  = pipeline_flow_ctrl_pkg::IDXW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rr_valid,
  input  logic             rr_uses_a,
  input  logic             rr_uses_b,
  input  logic [IDXW-1:0]  rr_src_a,
  input  logic [IDXW-1:0]  rr_src_b,
  input  logic             rr_is_lmsm,
  input  logic [NREGS-1:0] rr_reglist,
  input  logic             ex_valid,
  input  logic             ex_is_load,
  input  logic [IDXW-1:0]  ex_rd,
  input  logic             ex_branch_taken,
  input  logic             wb_r7_write,
  output logic             pc_write_n,
  output logic             pipe1_write_n,
  output logic             pipe2_write_n,
  output logic             pipe3_write_n,
  output logic             pipe4_write_n,
  output logic             pipe5_write_n,
  output logic             pipe1_flush,
  output logic             pipe2_flush,
  output logic             pipe3_flush,
  output logic             pipe4_flush,
  output logic             pipe5_flush,
  output logic             lmsm_active,
  output logic [IDXW-1:0]  lmsm_reg,
  output logic [IDXW:0]    lmsm_offset
);

  import pipeline_flow_ctrl_pkg::*;

  flow_state_e      state_q, state_d;
  logic [NREGS-1:0] mask_q, mask_d;
  logic [IDXW:0]    offset_q, offset_d;

  logic             load_use;
  logic             in_seq;
  logic             start;
  logic             seq_cycle;
  logic             issuing;
  logic [NREGS-1:0] scan_mask;
  logic [IDXW:0]    cur_offset;
  logic [IDXW-1:0]  scan_idx;
  logic             scan_any;
  logic             scan_last;

  logic                pc_hold;
  logic [NumPipes:1]   write_n_v;
  logic [NumPipes:1]   flush_v;

  always_comb begin
    load_use = ex_valid & ex_is_load & rr_valid &
               ((rr_uses_a & (rr_src_a == ex_rd)) | (rr_uses_b & (rr_src_b == ex_rd)));
    in_seq     = (state_q == StSeq);
    start      = ~in_seq & rr_valid & rr_is_lmsm;
    seq_cycle  = in_seq | start;
    // In SEQ the remaining mask drives the scan; on a start cycle the fresh list does.
    scan_mask  = in_seq ? mask_q : (start ? rr_reglist : '0);
    cur_offset = in_seq ? offset_q : '0;
  end

  lmsm_bitscan #(
    .Width(NREGS),
    .IdxW (IDXW)
  ) u_bitscan (
    .vec (scan_mask),
    .idx (scan_idx),
    .any (scan_any),
    .last(scan_last)
  );

  assign issuing = in_seq | (start & scan_any);

  // Event priority: R7 redirect > branch redirect > load-use > LM/SM > default.
  always_comb begin
    pc_hold   = 1'b0;
    write_n_v = '0;
    flush_v   = '0;
    state_d   = state_q;
    mask_d    = mask_q;
    offset_d  = offset_q;

    if (reset) begin
      // Outputs sit at reset values; the state register clears on the edge.
    end else if (wb_r7_write) begin
      flush_v[PipeIfId]  = 1'b1;
      flush_v[PipeIdRr]  = 1'b1;
      flush_v[PipeRrEx]  = 1'b1;
      flush_v[PipeExMem] = 1'b1;
      state_d  = StIdle;
      mask_d   = '0;
      offset_d = '0;
    end else if (ex_branch_taken) begin
      flush_v[PipeIfId] = 1'b1;
      flush_v[PipeIdRr] = 1'b1;
      flush_v[PipeRrEx] = 1'b1;
      state_d  = StIdle;
      mask_d   = '0;
      offset_d = '0;
    end else if (load_use) begin
      // Sequencer state is frozen; the load moves to MEM so this lasts one cycle.
      pc_hold            = 1'b1;
      write_n_v[PipeIfId] = 1'b1;
      write_n_v[PipeIdRr] = 1'b1;
      flush_v[PipeRrEx]  = 1'b1;
    end else if (seq_cycle) begin
      if (!scan_any) begin
        // Empty list: retire as a NOP.
        flush_v[PipeRrEx] = 1'b1;
      end else if (scan_last) begin
        state_d  = StIdle;
        mask_d   = '0;
        offset_d = '0;
      end else begin
        pc_hold             = 1'b1;
        write_n_v[PipeIfId] = 1'b1;
        write_n_v[PipeIdRr] = 1'b1;
        state_d  = StSeq;
        mask_d   = scan_mask & ~(NREGS'(1) << scan_idx);
        offset_d = cur_offset + (IDXW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      mask_q   <= '0;
      offset_q <= '0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      offset_q <= offset_d;
    end
  end

  assign pc_write_n    = pc_hold;
  assign pipe1_write_n = write_n_v[PipeIfId];
  assign pipe2_write_n = write_n_v[PipeIdRr];
  assign pipe3_write_n = write_n_v[PipeRrEx];
  assign pipe4_write_n = write_n_v[PipeExMem];
  assign pipe5_write_n = write_n_v[PipeMemWb];
  assign pipe1_flush   = flush_v[PipeIfId];
  assign pipe2_flush   = flush_v[PipeIdRr];
  assign pipe3_flush   = flush_v[PipeRrEx];
  assign pipe4_flush   = flush_v[PipeExMem];
  assign pipe5_flush   = flush_v[PipeMemWb];

  assign lmsm_active = ~reset & (in_seq | (start & scan_any & ~scan_last));
  assign lmsm_reg    = (~reset & issuing) ? scan_idx : '0;
  assign lmsm_offset = (~reset & issuing) ? cur_offset : '0;

endmodule
